f_fetch_stage: RTL and testbench

Fetch-stage program-counter unit of the 5-stage MIPS pipeline with precise exceptions. Holds the architectural fetch PC, drives the instruction-memory address, computes the next PC from the decode-stage control-flow decision, and flags fetch address errors. Its outputs feed the F/D pipeline register directly. Its redirect priorities match that register's, so both stages flush and redirect in the same cycle.

---
 rtl/f_fetch_stage_pkg.sv | 18 +
 rtl/f_fetch_stage_if.sv | 25 ++
 rtl/f_fetch_stage_npc_calc.sv | 23 ++
 rtl/f_fetch_stage.sv | 38 +++
 tb/tb_f_fetch_stage.sv | 112 +++++++++++
 5 files changed

// File: rtl/f_fetch_stage_pkg.sv
// cpu_defs: control-flow selectors, exception codes and fetch address map shared across stages
package cpu_defs;
  typedef enum logic [2:0] {
    NPC_SEQ = 3'd0,
    NPC_BR  = 3'd1,
    NPC_J   = 3'd2,
    NPC_JR  = 3'd3
  } npc_sel_e;
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] IM_LO_DEF      = 32'h0000_3000;
  localparam logic [31:0] IM_HI_DEF      = 32'h0000_6FFC;
  function automatic logic is_adel(input logic [31:0] pc, input logic [31:0] lo, input logic [31:0] hi);
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction
endpackage

// File: rtl/f_fetch_stage_if.sv
// f_fetch_stage_if: fetch-stage control inputs, instruction-memory port and F/D outputs
interface f_fetch_stage_if;
  logic        en;
  logic        req;
  logic        exl_clr;
  logic [31:0] epc;
  logic [2:0]  d_npc_sel;
  logic [31:0] d_pc;
  logic [15:0] d_imm16;
  logic [25:0] d_index26;
  logic [31:0] d_rs_value;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] f_pc;
  logic [31:0] f_command;
  logic [4:0]  f_exccode;
  modport master (
    output en, req, exl_clr, epc, d_npc_sel, d_pc, d_imm16, d_index26, d_rs_value, i_inst_rdata,
    input  i_inst_addr, f_pc, f_command, f_exccode
  );
  modport slave (
    input  en, req, exl_clr, epc, d_npc_sel, d_pc, d_imm16, d_index26, d_rs_value, i_inst_rdata,
    output i_inst_addr, f_pc, f_command, f_exccode
  );
endinterface

// File: rtl/f_fetch_stage_npc_calc.sv
// npc_calc: combinational next-PC mux driven by the decode-stage control-flow decision
module npc_calc
  import cpu_defs::*;
(
  input  logic [31:0] pc_i,
  input  logic [2:0]  sel_i,
  input  logic [31:0] d_pc_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] index26_i,
  input  logic [31:0] rs_value_i,
  output logic [31:0] npc_o
);
  logic [31:0] seq_pc, d_pc4, br_pc, j_pc;
  always_comb begin
    seq_pc = pc_i + 32'd4;
    d_pc4  = d_pc_i + 32'd4;
    br_pc  = d_pc4 + {{14{imm16_i[15]}}, imm16_i, 2'b00};
    j_pc   = {d_pc4[31:28], index26_i, 2'b00};
    npc_o  = sel_i == NPC_BR ? br_pc :
             sel_i == NPC_J  ? j_pc  :
             sel_i == NPC_JR ? rs_value_i : seq_pc;
  end
endmodule

// File: rtl/f_fetch_stage.sv
// f_fetch_stage: fetch PC register with exception/eret redirects, IM addressing and AdEL detection
module f_fetch_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter logic [31:0] IM_LO      = IM_LO_DEF,
  parameter logic [31:0] IM_HI      = IM_HI_DEF
)(
  input logic clk,
  input logic reset,
  f_fetch_stage_if.slave bus
);
  logic [31:0] pc_q, pc_d, npc;
  npc_calc u_npc (
    .pc_i       (pc_q),
    .sel_i      (bus.d_npc_sel),
    .d_pc_i     (bus.d_pc),
    .imm16_i    (bus.d_imm16),
    .index26_i  (bus.d_index26),
    .rs_value_i (bus.d_rs_value),
    .npc_o      (npc)
  );
  // Redirects bypass the stall so the F/D register and this stage flush together.
  always_comb
    pc_d = reset       ? RESET_PC   :
           bus.req     ? HANDLER_PC :
           bus.exl_clr ? bus.epc    :
           bus.en      ? npc        : pc_q;
  always_ff @(posedge clk)
    pc_q <= pc_d;
  always_comb begin
    bus.i_inst_addr = pc_q;
    bus.f_pc        = pc_q;
    bus.f_command   = bus.i_inst_rdata;
    bus.f_exccode   = is_adel(pc_q, IM_LO, IM_HI) ? EXC_ADEL : EXC_NONE;
  end
endmodule

// File: tb/tb_f_fetch_stage.sv
// tb_f_fetch_stage: directed vectors checked against a per-cycle architectural PC model plus literal pins
module tb_f_fetch_stage;
  logic clk = 1'b0;
  logic reset;
  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_pc = 32'h0;
  logic model_ok = 1'b0;
  f_fetch_stage_if bus();
  f_fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction
  assign bus.i_inst_rdata = mem_word(bus.i_inst_addr);
  function automatic logic [4:0] exp_exc(input logic [31:0] a);
    return (a % 4 != 0 || a < 32'h3000 || a > 32'h6FFC) ? 5'd4 : 5'd0;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask
  always @(posedge clk) begin
    logic [31:0] s;
    int off;
    s = bus.d_pc + 4;
    off = $signed(bus.d_imm16) * 4;
    if (reset) begin
      exp_pc = 32'h0000_3000;
      model_ok = 1'b1;
    end else if (bus.req) exp_pc = 32'h0000_4180;
    else if (bus.exl_clr) exp_pc = bus.epc;
    else if (bus.en) begin
      case (bus.d_npc_sel)
        3'd1: exp_pc = s + 32'(off);
        3'd2: exp_pc = (s & 32'hF000_0000) | (32'(bus.d_index26) * 4);
        3'd3: exp_pc = bus.d_rs_value;
        default: exp_pc = exp_pc + 4;
      endcase
    end
  end
  always @(negedge clk) if (model_ok) begin
    chk("m_f_pc", bus.f_pc, exp_pc);
    chk("m_inst_addr", bus.i_inst_addr, exp_pc);
    chk("m_command", bus.f_command, mem_word(exp_pc));
    chk("m_exccode", 32'(bus.f_exccode), 32'(exp_exc(exp_pc)));
  end
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic lit(input string name, input logic [31:0] pc, input logic [4:0] exc);
    chk({name, "_pc"}, bus.f_pc, pc);
    chk({name, "_exc"}, 32'(bus.f_exccode), 32'(exc));
  endtask
  initial begin
    reset = 1'b1;
    bus.en = 1'b0; bus.req = 1'b0; bus.exl_clr = 1'b0; bus.epc = 32'h0;
    bus.d_npc_sel = 3'd0; bus.d_pc = 32'h0; bus.d_imm16 = 16'h0;
    bus.d_index26 = 26'h0; bus.d_rs_value = 32'h0;
    step();
    lit("reset", 32'h3000, 5'd0);
    chk("reset_cmd", bus.f_command, mem_word(32'h3000));
    reset = 1'b0; bus.en = 1'b1;
    step(); lit("seq1", 32'h3004, 5'd0);
    step(); lit("seq2", 32'h3008, 5'd0);
    step(); lit("seq3", 32'h300C, 5'd0);
    step(); lit("seq4", 32'h3010, 5'd0);
    bus.d_npc_sel = 3'd1; bus.d_pc = 32'h300C; bus.d_imm16 = 16'hFFFC;
    step(); lit("br_back", 32'h3000, 5'd0);
    bus.d_imm16 = 16'h0004;
    step(); lit("br_fwd", 32'h3020, 5'd0);
    bus.d_npc_sel = 3'd2; bus.d_pc = 32'h3000; bus.d_index26 = 26'h0000C10;
    step(); lit("jump", 32'h3040, 5'd0);
    bus.d_pc = 32'h0FFF_FFFC; bus.d_index26 = 26'h0;
    step(); lit("j_carry", 32'h1000_0000, 5'd4);
    bus.d_npc_sel = 3'd3; bus.d_rs_value = 32'h3101;
    step(); lit("jr_unal", 32'h3101, 5'd4);
    bus.d_rs_value = 32'h7000;
    step(); lit("jr_hi", 32'h7000, 5'd4);
    bus.d_rs_value = 32'h2FFC;
    step(); lit("jr_lo", 32'h2FFC, 5'd4);
    bus.d_rs_value = 32'h6FFC;
    step(); lit("jr_edge", 32'h6FFC, 5'd0);
    bus.en = 1'b0; bus.d_npc_sel = 3'd1; bus.d_pc = 32'h3000;
    step(); lit("stall1", 32'h6FFC, 5'd0);
    step(); lit("stall2", 32'h6FFC, 5'd0);
    bus.req = 1'b1;
    step(); lit("req_stall", 32'h4180, 5'd0);
    bus.exl_clr = 1'b1; bus.epc = 32'h3050;
    step(); lit("req_eret", 32'h4180, 5'd0);
    bus.req = 1'b0;
    step(); lit("eret", 32'h3050, 5'd0);
    bus.exl_clr = 1'b0; bus.en = 1'b1; bus.d_npc_sel = 3'd5;
    step(); lit("sel5", 32'h3054, 5'd0);
    bus.d_npc_sel = 3'd3; bus.d_rs_value = 32'hFFFF_FFFC;
    step(); lit("top", 32'hFFFF_FFFC, 5'd4);
    bus.d_npc_sel = 3'd0;
    step(); lit("wrap", 32'h0000_0000, 5'd4);
    bus.d_npc_sel = 3'd3; bus.d_rs_value = 32'h3200;
    step(); lit("pc3200", 32'h3200, 5'd0);
    reset = 1'b1; bus.req = 1'b1;
    step(); lit("rst_req", 32'h3000, 5'd0);
    reset = 1'b0; bus.req = 1'b0; bus.d_npc_sel = 3'd0;
    step(); lit("post_rst", 32'h3004, 5'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
